serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial, LSB-first subtractor that computes A − B over WIDTH cycles using one half-subtractor pair and a registered borrow. It is the inverse arithmetic counterpart of the team's half-adder datapath, for area-constrained paths where latency is acceptable. A start/busy/done handshake lets a controller launch one operation and collect a held result.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start_i  input  1  launch request; sampled only in IDLE
a_i  input  WIDTH  minuend; captured on accepted start
b_i  input  WIDTH  subtrahend; captured on accepted start
busy_o  output  1  high from the cycle after an accepted start through the DONE cycle
done_o  output  1  one-cycle pulse when the result is valid
diff_o  output  WIDTH  (A − B) mod 2^WIDTH; registered, held until the next result
borrow_o  output  1  final borrow (1 when A < B unsigned); held with diff_o

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; busy_o=0, done_o=0, diff_o=0, borrow_o=0; internal shift registers, bit counter and borrow cleared.
- Reset asserted mid-operation aborts the operation. No done_o pulse is issued, and the outputs return to their reset values.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start_i=1 loads a_i and b_i into shift registers, clears borrow and counter, and moves to SHIFT. start_i=0 keeps IDLE.
- SHIFT, each cycle:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the MSB of the result register; operand registers shift right; counter increments.
  - After exactly WIDTH SHIFT cycles, go to DONE.
- DONE (one cycle): diff_o and borrow_o update from the result register and final borrow. done_o=1 this cycle only. Next state is IDLE.
- Latency: start accepted at edge N, done_o high in the cycle after edge N+WIDTH+1, i.e. WIDTH+1 busy cycles.
- start_i in SHIFT or DONE is ignored, not queued. Operands change while busy: no effect.
- start_i high in the first IDLE cycle after DONE is accepted, so back-to-back throughput is one result per WIDTH+2 cycles.
- diff_o and borrow_o never change outside the DONE cycle or reset.
- Counter width is $clog2(WIDTH)+1. It must not wrap before the terminal count.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: adds output ovf_o (1 bit), the signed two's-complement overflow flag, set when sign(A) ≠ sign(B) and sign(diff) ≠ sign(A).
  - Computed from the captured operand MSBs and the result MSB.
  - Updated in DONE with diff_o; reset to 0.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include serial_arith_pkg: FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) as localparams. Shared with the future serial adder.
- Sub-module half_subtractor (combinational: d = x ^ y, bo = ~x & y). Instantiated twice with an OR on the borrows to form the per-bit full subtractor.

Test Plan:
- Reset, then WIDTH=8, A=10, B=3, start pulse → done_o pulses exactly 9 cycles after the start edge; diff_o=7, borrow_o=0; busy_o high 9 cycles.
- A=3, B=10 → diff_o=249 (8'hF9), borrow_o=1.
- Boundary operands: A=0, B=0 → diff_o=0, borrow_o=0. A=255, B=255 → diff_o=0, borrow_o=0. A=0, B=1 → diff_o=255, borrow_o=1.
- Start during busy: start A=20, B=5, then pulse start with A=1, B=2 at cycle 3 → single done_o with diff_o=15; the second start is ignored. Back-to-back start in the cycle after DONE is accepted.
- Reset mid-op: rst_n=0 at cycle 4 of SHIFT → no done_o; outputs 0; a subsequent start A=9, B=4 → diff_o=5.
- With SERIAL_SUB_OVF_EN:
  - A=8'h80, B=8'h01 → diff_o=8'h7F, ovf_o=1.
  - A=8'h05, B=8'h03 → ovf_o=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder later).
// FSM state encodings are fixed so both blocks present identical state values.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/half_subtractor.sv
// Combinational half subtractor: d = x - y with borrow-out bo.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor producing (A - B) mod 2^WIDTH over WIDTH shift cycles.
// Optional signed-overflow output ovf_o is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    import serial_arith_pkg::*;

    // One spare bit so the counter can hold WIDTH without wrapping.
    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic d_ab, bo_ab, d_bit, bo_br;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;
`endif

    // Two half subtractors chained through the borrow form one full-subtractor bit.
    half_subtractor u_hs_ab (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .d  (d_ab),
        .bo (bo_ab)
    );

    half_subtractor u_hs_br (
        .x  (d_ab),
        .y  (br),
        .d  (d_bit),
        .bo (bo_br)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            br       <= 1'b0;
            cnt      <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_o    <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_sh   <= a_i;
                        b_sh   <= b_i;
                        res    <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= a_i[WIDTH-1];
                        b_msb  <= b_i[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {d_bit, res[WIDTH-1:1]};
                    br   <= bo_ab | bo_br;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    diff_o   <= res;
                    borrow_o <= br;
                    done_o   <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_o    <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8); checks ovf_o when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] diff_o;
    logic         borrow_o;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf_o;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .diff_o   (diff_o),
        .borrow_o (borrow_o)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf_o    (ovf_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation accepted at edge N yields its result at edge N+W+1.
    bit           model_on = 1'b0;
    bit           m_active = 1'b0;
    int           m_k      = 0;
    logic [W-1:0] m_a      = '0;
    logic [W-1:0] m_b      = '0;
    logic         m_done   = 1'b0;
    logic [W-1:0] m_diff   = '0;
    logic         m_borrow = 1'b0;
    logic         m_ovf    = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_on = 1'b1;
            m_active = 1'b0;
            m_k      = 0;
            m_done   = 1'b0;
            m_diff   = '0;
            m_borrow = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_k == W + 1) begin
                    m_done   = 1'b1;
                    m_diff   = m_a - m_b;
                    m_borrow = (m_a < m_b);
                    m_ovf    = (m_a[W-1] != m_b[W-1]) && (m_diff[W-1] != m_a[W-1]);
                    m_active = 1'b0;
                end
            end else if (start_i) begin
                m_active = 1'b1;
                m_k      = 0;
                m_a      = a_i;
                m_b      = b_i;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("cyc_done",   32'(done_o),   32'(m_done));
            chk("cyc_busy",   32'(busy_o),   32'(m_active));
            chk("cyc_diff",   32'(diff_o),   32'(m_diff));
            chk("cyc_borrow", 32'(borrow_o), 32'(m_borrow));
`ifdef SERIAL_SUB_OVF_EN
            chk("cyc_ovf",    32'(ovf_o),    32'(m_ovf));
`endif
        end
    end

    // Called at posedge+1; launches one operation and returns in the cycle where done_o is seen.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
        int lat = 0;
        int bc  = 0;
        bit got = 1'b0;
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i     = ~a;
        b_i     = ~b;
        if (busy_o) bc++;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy_o) bc++;
            if (done_o) got = 1'b1;
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_latency"},   32'(lat), 32'd9);
        chk({name, "_busy_cyc"},  32'(bc),  32'd9);
        chk({name, "_diff"},      32'(diff_o),   32'(ed));
        chk({name, "_borrow"},    32'(borrow_o), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk({name, "_ovf"},       32'(ovf_o),    32'(eo));
`else
        if (eo !== 1'b0 && eo !== 1'b1) chk({name, "_ovf_arg"}, 32'(eo), 32'd0);
`endif
    endtask

    initial begin
        int dones;
        logic [W-1:0] seen_diff;
        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy_o),   32'd0);
        chk("rst_done",   32'(done_o),   32'd0);
        chk("rst_diff",   32'(diff_o),   32'd0);
        chk("rst_borrow", 32'(borrow_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("a10_b3",  8'd10,  8'd3,  8'd7,   1'b0, 1'b0);
        do_op("a3_b10",  8'd3,   8'd10, 8'hF9,  1'b1, 1'b0);
        // The next three are launched in the first IDLE cycle after each result.
        do_op("a0_b0",   8'd0,   8'd0,  8'd0,   1'b0, 1'b0);
        do_op("a255_b255", 8'd255, 8'd255, 8'd0, 1'b0, 1'b0);
        do_op("a0_b1",   8'd0,   8'd1,  8'd255, 1'b1, 1'b0);

        // Second start while busy must be ignored.
        start_i = 1'b1;
        a_i = 8'd20;
        b_i = 8'd5;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        dones = 0;
        seen_diff = '0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 3) begin
                start_i = 1'b1;
                a_i = 8'd1;
                b_i = 8'd2;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done_o) begin
                dones++;
                seen_diff = diff_o;
            end
        end
        start_i = 1'b0;
        chk("busy_start_dones", 32'(dones),     32'd1);
        chk("busy_start_diff",  32'(seen_diff), 32'd15);

        // Reset in the fourth SHIFT cycle aborts the operation.
        start_i = 1'b1;
        a_i = 8'd100;
        b_i = 8'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_busy",   32'(busy_o),   32'd0);
        chk("midrst_diff",   32'(diff_o),   32'd0);
        chk("midrst_borrow", 32'(borrow_o), 32'd0);
        dones = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done_o) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        do_op("a9_b4", 8'd9, 8'd4, 8'd5, 1'b0, 1'b0);

        do_op("a80_b01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        do_op("a05_b03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
